// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
//   Widths, iteration count, add-3 threshold and FSM state encodings.
package bin2bcd_seq_pkg;

    localparam int unsigned BIN_W       = 16;
    localparam int unsigned BCD_W       = 16;
    localparam int unsigned DIG_W       = 4;
    localparam int unsigned N_DIG       = 5;
    localparam int unsigned SCR_W       = N_DIG * DIG_W;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned N_ITER      = 16;
    localparam int unsigned ADD3_THRESH = 5;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq.
//   start, bin          : request from the master
//   busy, done, bcd, ovf: status and result from the converter (slave)
interface bin2bcd_seq_if;

    logic                               start;
    logic [bin2bcd_seq_pkg::BIN_W-1:0]  bin;
    logic                               busy;
    logic                               done;
    logic [bin2bcd_seq_pkg::BCD_W-1:0]  bcd;
    logic                               ovf;

    modport master (output start, bin, input  busy, done, bcd, ovf);
    modport slave  (input  start, bin, output busy, done, bcd, ovf);

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
//   d   : scratch digit in
//   q_c : corrected digit (combinational)
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIG_W-1:0] d,
    output logic [DIG_W-1:0] q_c
);

    assign q_c = (d >= DIG_W'(ADD3_THRESH)) ? d + DIG_W'(3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double-dabble,
// one input bit per clock, MSB first).
//   clk : clock, rising edge
//   clr : asynchronous active-low reset
//   bus : slave side of bin2bcd_seq_if (start/bin in; busy/done/bcd/ovf out)
// A conversion accepted on edge E0 presents done, bcd and ovf 17 clocks later.
// With HOLD_ON_OVF set, an overflowed result (> 9999) leaves bcd/ovf untouched.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter bit HOLD_ON_OVF = 1'b0
)
(
    input  logic          clk,
    input  logic          clr,
    bin2bcd_seq_if.slave  bus
);

    logic [0:0]       state, state_n;
    logic [CNT_W-1:0] cnt,   cnt_n;
    logic [SCR_W-1:0] scr,   scr_n;
    logic [BIN_W-1:0] shreg, shreg_n;
    logic             busy,  busy_n;
    logic             done,  done_n;
    logic [BCD_W-1:0] bcd,   bcd_n;
    logic             ovf,   ovf_n;

    logic [SCR_W-1:0] fixed_c;
    logic [SCR_W-1:0] shifted_c;
    logic             res_ovf_c;

    // Per-digit add-3 correction of the scratch register
    for (genvar i = 0; i < int'(N_DIG); i++) begin : g_add3
        bcd_add3 u_add3 (
            .d   (scr[i*DIG_W +: DIG_W]),
            .q_c (fixed_c[i*DIG_W +: DIG_W])
        );
    end

    // Corrected scratch shifted left, pulling in the next binary MSB
    assign shifted_c = {fixed_c[SCR_W-2:0], shreg[BIN_W-1]};
    assign res_ovf_c = |shifted_c[SCR_W-1:BCD_W];

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            scr   <= '0;
            shreg <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            scr   <= scr_n;
            shreg <= shreg_n;
            busy  <= busy_n;
            done  <= done_n;
            bcd   <= bcd_n;
            ovf   <= ovf_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        scr_n   = scr;
        shreg_n = shreg;
        busy_n  = busy;
        done_n  = 1'b0;
        bcd_n   = bcd;
        ovf_n   = ovf;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                    scr_n   = '0;
                    shreg_n = bus.bin;
                    busy_n  = 1'b1;
                end
            end
            ST_SHIFT: begin
                scr_n   = shifted_c;
                shreg_n = {shreg[BIN_W-2:0], 1'b0};
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(N_ITER - 1)) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    // Held mode keeps the previous result on overflow
                    if (!(HOLD_ON_OVF && res_ovf_c)) begin
                        bcd_n = shifted_c[BCD_W-1:0];
                        ovf_n = res_ovf_c;
                    end
                end
            end
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.bcd  = bcd;
    assign bus.ovf  = ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: one instance with HOLD_ON_OVF=0 and one
// with HOLD_ON_OVF=1 receive identical requests; monitors check every done.
module tb_bin2bcd_seq;

    typedef struct {
        int unsigned cyc;
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk;
    logic clr;
    int unsigned cyc;
    int total;
    int bad;

    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] prev1_bcd;
    logic        prev1_ovf;
    logic [15:0] last0_bcd;
    logic        last0_ovf;

    bin2bcd_seq_if if0 ();
    bin2bcd_seq_if if1 ();

    bin2bcd_seq #(.HOLD_ON_OVF(1'b0)) u_dut0 (.clk(clk), .clr(clr), .bus(if0));
    bin2bcd_seq #(.HOLD_ON_OVF(1'b1)) u_dut1 (.clk(clk), .clr(clr), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] b);
        if0.start = s;
        if0.bin   = b;
        if1.start = s;
        if1.bin   = b;
    endtask

    // Expected results for an accepted edge whose following negedge sees cyc=a
    task automatic push_exp(input int unsigned a, input logic [15:0] b, input logic o);
        q0.push_back('{a + 16, b, o});
        if (!o) begin
            prev1_bcd = b;
            prev1_ovf = o;
        end
        q1.push_back('{a + 16, prev1_bcd, prev1_ovf});
        last0_bcd = b;
        last0_ovf = o;
    endtask

    // Wait for idle, request one conversion, return at the negedge after E0
    task automatic issue(input logic [15:0] b, input logic [15:0] eb, input logic eo,
                         output int unsigned a);
        int k;
        k = 0;
        while (if0.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(if0.busy), 32'd0);
        drive(1'b1, b);
        @(posedge clk);
        @(negedge clk);
        a = cyc;
        drive(1'b0, b);
        push_exp(a, eb, eo);
        check("busy0", 32'(if0.busy), 32'd1);
        check("busy1", 32'(if1.busy), 32'd1);
    endtask

    // Monitor, HOLD_ON_OVF=0 instance
    always @(negedge clk) begin
        if (clr && if0.done) begin
            if (q0.size() == 0) begin
                check("unexp_done0", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("lat0", cyc, e.cyc);
                check("bcd0", 32'(if0.bcd), 32'(e.bcd));
                check("ovf0", 32'(if0.ovf), 32'(e.ovf));
            end
        end
    end

    // Monitor, HOLD_ON_OVF=1 instance
    always @(negedge clk) begin
        if (clr && if1.done) begin
            if (q1.size() == 0) begin
                check("unexp_done1", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("lat1", cyc, e.cyc);
                check("bcd1", 32'(if1.bcd), 32'(e.bcd));
                check("ovf1", 32'(if1.ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        int k;
        total = 0;
        bad = 0;
        prev1_bcd = '0;
        prev1_ovf = 1'b0;
        last0_bcd = '0;
        last0_ovf = 1'b0;
        clr = 1'b0;
        drive(1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_bcd0", 32'(if0.bcd), 32'd0);
        check("rst_ovf0", 32'(if0.ovf), 32'd0);
        check("rst_busy0", 32'(if0.busy), 32'd0);
        check("rst_done0", 32'(if0.done), 32'd0);
        check("rst_bcd1", 32'(if1.bcd), 32'd0);
        clr = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed BCD
        issue(16'h04D2, 16'h1234, 1'b0, a);
        issue(16'h2710, 16'h0000, 1'b1, a);
        issue(16'hFFFF, 16'h5535, 1'b1, a);
        issue(16'h270F, 16'h9999, 1'b0, a);
        issue(16'h0000, 16'h0000, 1'b0, a);
        issue(16'h0001, 16'h0001, 1'b0, a);
        issue(16'h03E8, 16'h1000, 1'b0, a);
        issue(16'h2710, 16'h0000, 1'b1, a);

        // Start pulse during a conversion is ignored
        issue(16'h04D2, 16'h1234, 1'b0, a);
        repeat (5) @(negedge clk);
        drive(1'b1, 16'h0063);
        @(negedge clk);
        drive(1'b0, 16'h0063);

        // Start held high through done: second request accepted in done cycle
        k = 0;
        while (if0.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        drive(1'b1, 16'h04D2);
        @(posedge clk);
        @(negedge clk);
        a = cyc;
        push_exp(a, 16'h1234, 1'b0);
        repeat (4) @(negedge clk);
        drive(1'b1, 16'h0063);
        repeat (12) @(negedge clk);
        check("held_done", 32'(if0.done), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0063);
        push_exp(cyc, 16'h0099, 1'b0);
        check("held_busy", 32'(if0.busy), 32'd1);

        // Reset mid-conversion aborts with no done
        issue(16'h270F, 16'h9999, 1'b0, a);
        issue(16'h0457, 16'h1111, 1'b0, a);
        repeat (8) @(negedge clk);
        clr = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        prev1_bcd = '0;
        prev1_ovf = 1'b0;
        check("abort_bcd0", 32'(if0.bcd), 32'd0);
        check("abort_busy0", 32'(if0.busy), 32'd0);
        check("abort_bcd1", 32'(if1.bcd), 32'd0);
        check("abort_busy1", 32'(if1.busy), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_nodone", 32'(if0.done), 32'd0);
        issue(16'h0063, 16'h0099, 1'b0, a);

        // Overflow after a valid result: held instance keeps 0x0099
        issue(16'hFFFF, 16'h5535, 1'b1, a);

        // Drain scoreboards
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain0", 32'(q0.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);

        // Results hold between completions
        repeat (5) @(negedge clk);
        check("hold_bcd0", 32'(if0.bcd), 32'(last0_bcd));
        check("hold_ovf0", 32'(if0.ovf), 32'(last0_ovf));
        check("hold_bcd1", 32'(if1.bcd), 32'(prev1_bcd));
        check("hold_ovf1", 32'(if1.ovf), 32'(prev1_ovf));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: HOLD_ON_OVF, default 0; when 1, bcd/ovf outputs do not update on an overflowed conversion (done still pulses).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  conversion request, sampled only in IDLE.
REQ-005 Port: bin  input  16  unsigned binary operand, captured on the accepting edge.
REQ-006 Port: busy  output  1  high while a conversion is in progress.
REQ-007 Port: done  output  1  single-cycle pulse marking valid new bcd/ovf.
REQ-008 Port: bcd  output  16  packed BCD, 4 digits, [3:0] = units, [15:12] = thousands; feeds the 7-segment driver's 16-bit digit input directly.
REQ-009 Port: ovf  output  1  high when the last accepted result was > 9999.

Function
REQ-010 The block SHALL convert bin to BCD by sequential double-dabble: one input bit per cycle, MSB first, 16 iterations.
REQ-011 FSM states SHALL be IDLE, SHIFT; IDLE->SHIFT on start=1; SHIFT->IDLE after iteration 16; no other transitions.
REQ-012 Internal scratch SHALL be 20 bits BCD (5 digits) plus a 16-bit shift register and a 5-bit iteration counter.
REQ-013 Each SHIFT cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shreg} left by 1.
REQ-014 Accepting edge E0 (IDLE, start=1): capture bin, clear scratch, clear counter; busy=1 from the cycle after E0.
REQ-015 Edges E1..E16 perform the 16 iterations; at E16 bcd <= scratch result [15:0], ovf <= (digit 4 != 0), done <= 1, busy <= 0.
REQ-016 Latency: done high in the cycle after E16, i.e. exactly 17 clocks after the accepting edge; bcd/ovf valid in that same cycle.
REQ-017 done SHALL be high for exactly one cycle per accepted conversion.
REQ-018 bcd and ovf SHALL hold their values between completions.
REQ-019 start while busy=1 SHALL be ignored, with no queuing; bin changes during SHIFT SHALL have no effect.
REQ-020 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted; back-to-back throughput is one result per 17 cycles.
REQ-021 With HOLD_ON_OVF=1 and result > 9999, bcd/ovf SHALL keep their prior values; done still pulses.
REQ-022 Overflowed outputs (HOLD_ON_OVF=0) SHALL be the low 4 BCD digits of the true value, e.g. 65535 gives bcd=0x5535, ovf=1.

Reset
REQ-023 clr=0 SHALL asynchronously force state=IDLE, busy=0, done=0, bcd=0x0000, ovf=0, and clear the counter, scratch and shift register.
REQ-024 Reset during SHIFT SHALL abort the conversion with no done pulse; the first start after clr rises begins a fresh conversion.

Structure
REQ-025 The shared package SHALL hold the state enumeration, N_ITER=16, and the add-3 threshold constant 5.
REQ-026 Digit correction SHALL be one combinational sub-module, bcd_add3 (4-bit in, 4-bit out), instantiated 5 times.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-028 Reset, then start with bin=0x04D2 (1234) -> done exactly 17 cycles later, bcd=0x1234, ovf=0.
REQ-029 bin=0x270F (9999) -> bcd=0x9999, ovf=0; bin=0x0000 -> bcd=0x0000, ovf=0.
REQ-030 bin=0x2710 (10000) -> bcd=0x0000, ovf=1; bin=0xFFFF -> bcd=0x5535, ovf=1; with HOLD_ON_OVF=1, both leave prior bcd unchanged and done still pulses.
REQ-031 Start 1234, then pulse start with bin=0x0063 at cycle 5 -> ignored, result 0x1234; start held high through done -> second conversion accepted in the done cycle.
REQ-032 clr=0 at cycle 8 of a conversion -> outputs zero immediately, no done pulse; next start with 0x0063 (99) -> bcd=0x0099 after 17 cycles.
